// File: rtl/serial_monitor_pkg.sv
// serial_monitor_pkg: command/response bytes and state encodings shared by the monitor
package serial_monitor_pkg;

    localparam logic [7:0] CMD_W    = 8'h57;
    localparam logic [7:0] CMD_R    = 8'h52;
    localparam logic [7:0] CMD_X    = 8'h58;
    localparam logic [7:0] RSP_OK   = 8'h2E;
    localparam logic [7:0] RSP_ERR  = 8'h3F;
    localparam logic [7:0] RSP_HALT = 8'h48;

    typedef enum logic [3:0] {
        IDLE, ARGHI, ARGLO, ARGLEN, WRDATA, RDADDR, RDWAIT, RDLATCH,
        TXWAIT, LAUNCH, RUN, HALTACK
    } mon_state_t;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_HOLD} txq_state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return b == CMD_W || b == CMD_R || b == CMD_X;
    endfunction

endpackage

// File: rtl/serial_monitor_if.sv
// serial_monitor_if: UART, RAM and CPU-control signals seen by the monitor
interface serial_monitor_if #(parameter int addr_width = 9);

    logic [7:0]            rx_byte;
    logic                  received;
    logic [7:0]            tx_byte;
    logic                  transmit;
    logic                  is_transmitting;
    logic [addr_width-1:0] m_raddr;
    logic [7:0]            m_dread;
    logic [addr_width-1:0] m_waddr;
    logic [7:0]            m_dwrite;
    logic                  m_write_en;
    logic                  cpu_start;
    logic [addr_width-1:0] cpu_startaddr;
    logic                  cpu_halted;
    logic                  cpu_active;

    modport master (
        input  rx_byte, received, is_transmitting, m_dread, cpu_halted,
        output tx_byte, transmit, m_raddr, m_waddr, m_dwrite, m_write_en,
               cpu_start, cpu_startaddr, cpu_active
    );

    modport slave (
        output rx_byte, received, is_transmitting, m_dread, cpu_halted,
        input  tx_byte, transmit, m_raddr, m_waddr, m_dwrite, m_write_en,
               cpu_start, cpu_startaddr, cpu_active
    );

endinterface

// File: rtl/serial_monitor_txq.sv
// serial_monitor_txq: sends one byte per req, waiting out a busy UART and its busy-flag latency
module serial_monitor_txq
    import serial_monitor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] data,
    input  logic       is_transmitting,
    output logic [7:0] tx_byte,
    output logic       transmit,
    output logic       done
);

    txq_state_t state;

    // latch byte, wait for idle transmitter, pulse transmit, hold one cycle, then report done
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= TX_IDLE;
            tx_byte  <= 8'd0;
            transmit <= 1'b0;
            done     <= 1'b0;
        end else begin
            transmit <= 1'b0;
            done     <= 1'b0;
            case (state)
                TX_IDLE: if (req) begin
                    tx_byte <= data;
                    state   <= TX_START;
                end
                TX_START: if (!is_transmitting) begin
                    transmit <= 1'b1;
                    state    <= TX_HOLD;
                end
                TX_HOLD: begin
                    done  <= 1'b1;
                    state <= TX_IDLE;
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/serial_monitor.sv
// serial_monitor: byte-serial command decoder for RAM download/dump and CPU launch
module serial_monitor
    import serial_monitor_pkg::*;
#(
    parameter int addr_width = 9
) (
    input logic clk,
    input logic rst,
    serial_monitor_if.master bus
);

    mon_state_t            state, ret;
    logic [7:0]            cmd, arg_hi, tx_data, m_dwrite;
    logic [addr_width-1:0] addr, m_raddr, m_waddr, cpu_startaddr;
    logic [8:0]            len;
    logic                  m_write_en, cpu_start, cpu_active, tx_req, tx_done;

    serial_monitor_txq u_txq (
        .clk             (clk),
        .rst             (rst),
        .req             (tx_req),
        .data            (tx_data),
        .is_transmitting (bus.is_transmitting),
        .tx_byte         (bus.tx_byte),
        .transmit        (bus.transmit),
        .done            (tx_done)
    );

    assign bus.m_raddr       = m_raddr;
    assign bus.m_waddr       = m_waddr;
    assign bus.m_dwrite      = m_dwrite;
    assign bus.m_write_en    = m_write_en;
    assign bus.cpu_start     = cpu_start;
    assign bus.cpu_startaddr = cpu_startaddr;
    assign bus.cpu_active    = cpu_active;

    // command sequencer; every transmitted byte goes through txq and resumes at ret
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ret           <= IDLE;
            cmd           <= 8'd0;
            arg_hi        <= 8'd0;
            tx_data       <= 8'd0;
            tx_req        <= 1'b0;
            addr          <= '0;
            len           <= 9'd0;
            m_raddr       <= '0;
            m_waddr       <= '0;
            m_dwrite      <= 8'd0;
            m_write_en    <= 1'b0;
            cpu_start     <= 1'b0;
            cpu_startaddr <= '0;
            cpu_active    <= 1'b0;
        end else begin
            m_write_en <= 1'b0;
            cpu_start  <= 1'b0;
            tx_req     <= 1'b0;
            case (state)
                IDLE: if (bus.received) begin
                    cmd <= bus.rx_byte;
                    if (is_cmd(bus.rx_byte)) state <= ARGHI;
                    else begin
                        tx_data <= RSP_ERR;
                        tx_req  <= 1'b1;
                        ret     <= IDLE;
                        state   <= TXWAIT;
                    end
                end
                ARGHI: if (bus.received) begin
                    arg_hi <= bus.rx_byte;
                    state  <= ARGLO;
                end
                ARGLO: if (bus.received) begin
                    addr  <= addr_width'({arg_hi, bus.rx_byte});
                    state <= (cmd == CMD_X) ? LAUNCH : ARGLEN;
                end
                ARGLEN: if (bus.received) begin
                    len   <= {bus.rx_byte == 8'd0, bus.rx_byte};
                    state <= (cmd == CMD_W) ? WRDATA : RDADDR;
                end
                WRDATA: if (bus.received) begin
                    m_write_en <= 1'b1;
                    m_waddr    <= addr;
                    m_dwrite   <= bus.rx_byte;
                    addr       <= addr + 1'b1;
                    len        <= len - 1'b1;
                    if (len == 9'd1) begin
                        tx_data <= RSP_OK;
                        tx_req  <= 1'b1;
                        ret     <= IDLE;
                        state   <= TXWAIT;
                    end
                end
                RDADDR: begin
                    m_raddr <= addr;
                    addr    <= addr + 1'b1;
                    len     <= len - 1'b1;
                    state   <= RDWAIT;
                end
                RDWAIT: state <= RDLATCH;
                RDLATCH: begin
                    tx_data <= bus.m_dread;
                    tx_req  <= 1'b1;
                    ret     <= (len == 9'd0) ? IDLE : RDADDR;
                    state   <= TXWAIT;
                end
                TXWAIT: if (tx_done) state <= ret;
                LAUNCH: begin
                    cpu_start     <= 1'b1;
                    cpu_active    <= 1'b1;
                    cpu_startaddr <= addr;
                    state         <= RUN;
                end
                RUN: if (bus.cpu_halted) begin
                    cpu_active <= 1'b0;
                    state      <= HALTACK;
                end
                HALTACK: begin
                    tx_data <= RSP_HALT;
                    tx_req  <= 1'b1;
                    ret     <= IDLE;
                    state   <= TXWAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_monitor.sv
// tb_serial_monitor: directed command vectors against RAM/UART/CPU models
module tb_serial_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_monitor_if #(.addr_width(9)) bus ();
    serial_monitor #(.addr_width(9)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    logic [7:0] ram [512];
    logic       pl_en = 1'b0;
    logic [8:0] pl_addr = 9'd0;
    logic [7:0] pl_data = 8'd0;

    // synchronous-read RAM with a bench preload port
    always @(posedge clk) begin
        if (bus.m_write_en) ram[bus.m_waddr] <= bus.m_dwrite;
        if (pl_en) ram[pl_addr] <= pl_data;
        bus.m_dread <= ram[bus.m_raddr];
    end

    logic [7:0] txlog[$];
    int busy = 0;
    int wcount = 0;
    int scount = 0;
    logic act_at_start = 1'b0;

    // UART transmitter model plus pulse counters
    always @(negedge clk) begin
        if (bus.transmit) begin
            chk("tx_while_busy", 32'(bus.is_transmitting), 32'd0);
            txlog.push_back(bus.tx_byte);
            busy = 6;
        end else if (busy > 0) busy--;
        bus.is_transmitting = (busy != 0);
        if (bus.m_write_en) wcount++;
        if (bus.cpu_start) begin
            scount++;
            act_at_start = bus.cpu_active;
        end
    end

    task automatic send(input logic [7:0] b);
        bus.rx_byte  = b;
        bus.received = 1'b1;
        @(negedge clk);
        bus.received = 1'b0;
        @(negedge clk);
    endtask

    task automatic preload(input logic [8:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] exp);
        int n = 0;
        while (txlog.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (txlog.size() == 0) chk({tag, "_timeout"}, 32'(txlog.size()), 32'd1);
        else chk(tag, 32'(txlog.pop_front()), 32'(exp));
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_tx_byte"}, 32'(bus.tx_byte), 32'd0);
        chk({p, "_transmit"}, 32'(bus.transmit), 32'd0);
        chk({p, "_m_write_en"}, 32'(bus.m_write_en), 32'd0);
        chk({p, "_m_waddr"}, 32'(bus.m_waddr), 32'd0);
        chk({p, "_m_dwrite"}, 32'(bus.m_dwrite), 32'd0);
        chk({p, "_m_raddr"}, 32'(bus.m_raddr), 32'd0);
        chk({p, "_cpu_start"}, 32'(bus.cpu_start), 32'd0);
        chk({p, "_cpu_active"}, 32'(bus.cpu_active), 32'd0);
        chk({p, "_cpu_startaddr"}, 32'(bus.cpu_startaddr), 32'd0);
    endtask

    initial begin
        bus.rx_byte    = 8'd0;
        bus.received   = 1'b0;
        bus.cpu_halted = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // download three bytes
        wcount = 0;
        send(8'h57); send(8'h00); send(8'h10); send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC);
        expect_tx("w_ok", 8'h2E);
        chk("w_ram10", 32'(ram[9'h010]), 32'hAA);
        chk("w_ram11", 32'(ram[9'h011]), 32'hBB);
        chk("w_ram12", 32'(ram[9'h012]), 32'hCC);
        chk("w_count", 32'(wcount), 32'd3);

        // unknown byte, then a working download with high address bit
        send(8'h41);
        expect_tx("err", 8'h3F);
        send(8'h57); send(8'h01); send(8'h00); send(8'h01); send(8'h5A);
        expect_tx("w2_ok", 8'h2E);
        chk("w2_ram100", 32'(ram[9'h100]), 32'h5A);

        // dump across the top of the address space
        preload(9'h1FF, 8'h11);
        preload(9'h000, 8'h22);
        send(8'h52); send(8'h01); send(8'hFF); send(8'h02);
        expect_tx("r_b0", 8'h11);
        expect_tx("r_b1", 8'h22);

        // launch, run, halt
        scount = 0;
        send(8'h58); send(8'h00); send(8'h20);
        for (int i = 0; i < 20 && scount == 0; i++) @(negedge clk);
        chk("x_start_count", 32'(scount), 32'd1);
        chk("x_active_with_start", 32'(act_at_start), 32'd1);
        chk("x_startaddr", 32'(bus.cpu_startaddr), 32'h020);
        send(8'h41);
        repeat (46) @(negedge clk);
        chk("x_single_start", 32'(scount), 32'd1);
        chk("x_active_run", 32'(bus.cpu_active), 32'd1);
        chk("x_no_tx_in_run", 32'(txlog.size()), 32'd0);
        bus.cpu_halted = 1'b1;
        chk("x_active_at_halt", 32'(bus.cpu_active), 32'd1);
        @(negedge clk);
        bus.cpu_halted = 1'b0;
        chk("x_active_after_halt", 32'(bus.cpu_active), 32'd0);
        expect_tx("x_halt", 8'h48);

        // reset in the middle of a download, then a dump of what landed
        send(8'h57); send(8'h00); send(8'h30); send(8'h05);
        send(8'h77); send(8'h88);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("mid");
        rst = 1'b0;
        @(negedge clk);
        send(8'h52); send(8'h00); send(8'h30); send(8'h01);
        expect_tx("rst_r", 8'h77);

        // len=0 means 256 bytes
        preload(9'h100, 8'hEE);
        wcount = 0;
        send(8'h57); send(8'h00); send(8'h00); send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A);
        expect_tx("w256_ok", 8'h2E);
        chk("w256_count", 32'(wcount), 32'd256);
        chk("w256_ram000", 32'(ram[9'h000]), 32'h5A);
        chk("w256_ram080", 32'(ram[9'h080]), 32'hDA);
        chk("w256_ram0ff", 32'(ram[9'h0FF]), 32'hA5);
        chk("w256_ram100", 32'(ram[9'h100]), 32'hEE);

        repeat (10) @(negedge clk);
        chk("no_extra_tx", 32'(txlog.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
